// File: rtl/led_ctrl_multi.sv
// Multi-channel LED controller: reset synchroniser, shared tick prescaler, per-channel off/blink/PWM/pulse.
// Latency: led registered; mode change -> led 0 after 1 cycle, trig rise -> led 1 after 2 cycles, tick effects 1 cycle after tick.
// Backpressure: none; all outputs free-running, no flow control.
module led_ctrl_multi #(
    parameter int NCH         = 4,
    parameter int TICK_DIV    = 32000,
    parameter int PERIOD_BITS = 16,
    parameter int PWM_BITS    = 8,
    parameter int RST_STAGES  = 2
) (
    input  logic                         pixel_clk,
    input  logic                         sys_rst,
    output logic                         rst_sync,
    input  logic [2*NCH-1:0]             mode,
    input  logic [PERIOD_BITS*NCH-1:0]   half_period,
    input  logic [PWM_BITS*NCH-1:0]      duty,
    input  logic [NCH-1:0]               trig,
    output logic                         tick,
    output logic [NCH-1:0]               led
);

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_BLINK = 2'd1,
        MODE_PWM   = 2'd2,
        MODE_PULSE = 2'd3
    } mode_e;

    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    logic [RST_STAGES-1:0] rst_chain;
    logic [PRE_W-1:0]      pre_cnt;
    logic [PWM_BITS-1:0]   phase;

    // Reset synchroniser: asserts asynchronously, releases after RST_STAGES clean edges.
    always_ff @(posedge pixel_clk or posedge sys_rst) begin
        if (sys_rst) begin
            rst_chain <= '1;
        end else begin
            rst_chain <= {rst_chain[RST_STAGES-2:0], 1'b0};
        end
    end

    assign rst_sync = rst_chain[RST_STAGES-1];

    // Tick prescaler: strobe for one cycle after the counter's terminal value.
    always_ff @(posedge pixel_clk or posedge rst_sync) begin
        if (rst_sync) begin
            pre_cnt <= '0;
            tick    <= 1'b0;
        end else begin
            tick    <= (pre_cnt == PRE_LAST);
            pre_cnt <= (pre_cnt == PRE_LAST) ? '0 : pre_cnt + 1'b1;
        end
    end

    // Shared PWM phase, free-running and wrapping naturally at full scale.
    always_ff @(posedge pixel_clk or posedge rst_sync) begin
        if (rst_sync) begin
            phase <= '0;
        end else begin
            phase <= phase + 1'b1;
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        mode_e                  mode_i;
        mode_e                  mode_q;
        logic [PERIOD_BITS-1:0] hp_i;
        logic [PERIOD_BITS-1:0] len_i;
        logic [PERIOD_BITS-1:0] cnt;
        logic [PWM_BITS-1:0]    duty_i;
        logic                   trig_s;
        logic                   trig_q;
        logic                   rise;
        logic                   led_r;

        assign mode_i = mode_e'(mode[2*i +: 2]);
        assign hp_i   = half_period[PERIOD_BITS*i +: PERIOD_BITS];
        assign duty_i = duty[PWM_BITS*i +: PWM_BITS];
        // A zero length would never complete a compare, so it behaves as one tick.
        assign len_i  = (hp_i == '0) ? PERIOD_BITS'(1) : hp_i;
        assign rise   = trig_s & ~trig_q;
        assign led[i] = led_r;

        // Trigger history: sample then delay, so edges are seen on registered values only.
        always_ff @(posedge pixel_clk or posedge rst_sync) begin
            if (rst_sync) begin
                trig_s <= 1'b0;
                trig_q <= 1'b0;
            end else begin
                trig_s <= trig[i];
                trig_q <= trig_s;
            end
        end

        // Channel engine: a mode change clears the channel for one cycle, otherwise run the mode.
        always_ff @(posedge pixel_clk or posedge rst_sync) begin
            if (rst_sync) begin
                mode_q <= MODE_OFF;
                cnt    <= '0;
                led_r  <= 1'b0;
            end else begin
                mode_q <= mode_i;
                if (mode_i != mode_q) begin
                    cnt   <= '0;
                    led_r <= 1'b0;
                end else begin
                    case (mode_i)
                        MODE_OFF: begin
                            cnt   <= '0;
                            led_r <= 1'b0;
                        end
                        MODE_BLINK: begin
                            // >= so a shortened half-period toggles on the very next tick.
                            if (tick) begin
                                if (cnt >= len_i - PERIOD_BITS'(1)) begin
                                    cnt   <= '0;
                                    led_r <= ~led_r;
                                end else begin
                                    cnt <= cnt + 1'b1;
                                end
                            end
                        end
                        MODE_PWM: begin
                            led_r <= (phase < duty_i);
                        end
                        MODE_PULSE: begin
                            // Reload has priority over a coinciding tick.
                            if (rise) begin
                                cnt   <= len_i;
                                led_r <= 1'b1;
                            end else if (tick && (cnt != '0)) begin
                                cnt <= cnt - 1'b1;
                                if (cnt == PERIOD_BITS'(1)) begin
                                    led_r <= 1'b0;
                                end
                            end
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_led_ctrl_multi.sv
// Self-checking bench for led_ctrl_multi: directed sequences, vector table, random vs reference model.
// Latency: n/a (bench).
// Backpressure: n/a (bench).
module tb_led_ctrl_multi;

    localparam int NCH = 4;
    localparam int TD  = 4;
    localparam int PB  = 16;
    localparam int WB  = 8;
    localparam int RS  = 2;

    logic                pixel_clk = 1'b0;
    logic                sys_rst   = 1'b0;
    logic                rst_sync;
    logic [2*NCH-1:0]    mode;
    logic [PB*NCH-1:0]   half_period;
    logic [WB*NCH-1:0]   duty;
    logic [NCH-1:0]      trig;
    logic                tick;
    logic [NCH-1:0]      led;

    int n_cmp = 0;
    int n_bad = 0;
    int ecnt  = 0;

    typedef struct {
        int         ch;
        logic [1:0] md;
        int         hp;
        int         dt;
        int         win;
        int         exp_hi;
        int         exp_tg;
    } vec_t;

    vec_t vt[7];

    always #5 pixel_clk = ~pixel_clk;

    led_ctrl_multi #(
        .NCH(NCH), .TICK_DIV(TD), .PERIOD_BITS(PB), .PWM_BITS(WB), .RST_STAGES(RS)
    ) dut (
        .pixel_clk   (pixel_clk),
        .sys_rst     (sys_rst),
        .rst_sync    (rst_sync),
        .mode        (mode),
        .half_period (half_period),
        .duty        (duty),
        .trig        (trig),
        .tick        (tick),
        .led         (led)
    );

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge pixel_clk);
        #1;
        ecnt++;
    endtask

    task automatic reset_release();
        sys_rst = 1'b1;
        mode = '0; half_period = '0; duty = '0; trig = '0;
        #7;
        sys_rst = 1'b0;
        repeat (RS) @(posedge pixel_clk);
        #1;
        ecnt = 0;
    endtask

    task automatic set_ch(input int ch, input logic [1:0] md, input int hp, input int dt);
        mode[2*ch +: 2]         = md;
        half_period[PB*ch +: PB] = PB'(hp);
        duty[WB*ch +: WB]        = WB'(dt);
    endtask

    task automatic wait_led(input int ch, input logic val, input int bound, output int at);
        at = -1;
        for (int i = 0; i < bound; i++) begin
            step();
            if (led[ch] === val) begin
                at = ecnt;
                break;
            end
        end
    endtask

    // Edge index of the k-th tick-consuming edge strictly after edge 'after'.
    function automatic int next_tick_edge(input int after, input int k);
        int e = after;
        int c = 0;
        while (c < k) begin
            e++;
            if (e > 1 && ((e - 1) % TD) == 0) c++;
        end
        return e;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int at, hi, tg, r1, r2;
        logic prev;
        int pm[NCH], ent[NCH], endt[NCH];
        logic th1[NCH], th2[NCH];
        logic [NCH-1:0] expv;

        vt[0] = '{0, 2'd1, 3, 0,   240, 120, 20};
        vt[1] = '{0, 2'd1, 0, 0,   240, 120, 60};
        vt[2] = '{0, 2'd1, 5, 0,   240, 120, 12};
        vt[3] = '{1, 2'd2, 0, 64,  256, 64,  2};
        vt[4] = '{1, 2'd2, 0, 0,   256, 0,   0};
        vt[5] = '{1, 2'd2, 0, 255, 256, 255, 2};
        vt[6] = '{3, 2'd0, 2, 200, 100, 0,   0};

        // Power-on reset is asynchronous.
        mode = '0; half_period = '0; duty = '0; trig = '0;
        sys_rst = 1'b1;
        #1;
        check("por_rst_sync", rst_sync, 1);
        check("por_led", led, 0);
        check("por_tick", tick, 0);

        // Mid-blink 1 ns reset pulse: immediate clear, 2-edge release, tick phase restart.
        reset_release();
        set_ch(0, 2'd1, 0, 0);
        wait_led(0, 1'b1, 40, at);
        check("blink_up_before_rst", at, 5);
        #2;
        sys_rst = 1'b1;
        #1;
        check("rst_async_sync", rst_sync, 1);
        check("rst_async_led", led, 0);
        check("rst_async_tick", tick, 0);
        sys_rst = 1'b0;
        @(posedge pixel_clk); #1;
        check("rst_hold_edge1", rst_sync, 1);
        @(posedge pixel_clk); #1;
        check("rst_fall_edge2", rst_sync, 0);
        ecnt = 0;
        for (int e = 1; e <= 12; e++) begin
            step();
            check($sformatf("tick_e%0d", e), tick, (ecnt % TD) == 0);
        end

        // Blink half_period 3, then live change to 0, then switch to PWM while lit.
        reset_release();
        set_ch(0, 2'd1, 3, 0);
        wait_led(0, 1'b1, 40, at);
        check("blink3_first_rise", at, 13);
        wait_led(0, 1'b0, 40, at);
        check("blink3_first_fall", at, 25);
        set_ch(0, 2'd1, 0, 0);
        wait_led(0, 1'b1, 40, at);
        check("blink0_rise", at, 29);
        wait_led(0, 1'b0, 40, at);
        check("blink0_fall", at, 33);
        wait_led(0, 1'b1, 40, at);
        set_ch(0, 2'd2, 0, 128);
        step();
        check("modesw_zero", led[0], 0);
        for (int k = 0; k < 4; k++) begin
            step();
            check("modesw_pwm", led[0], ((ecnt - 1) % 256) < 128);
        end

        // Pulse: trigger latency, expiry, held trigger, retrigger extension.
        reset_release();
        set_ch(2, 2'd3, 2, 0);
        step();
        step();
        trig[2] = 1'b1;
        step();
        check("trig_lat_1", led[2], 0);
        step();
        check("trig_lat_2", led[2], 1);
        wait_led(2, 1'b0, 60, at);
        check("pulse_fall", at, next_tick_edge(4, 2));
        hi = 0;
        repeat (10) begin
            step();
            if (led[2]) hi++;
        end
        check("held_no_retrig", hi, 0);
        trig[2] = 1'b0;
        step();
        trig[2] = 1'b1;
        step();
        step();
        r1 = ecnt;
        check("retrig_first_up", led[2], 1);
        for (int k = 0; k < 20 && ecnt < next_tick_edge(r1, 1); k++) step();
        check("retrig_mid", led[2], 1);
        trig[2] = 1'b0;
        step();
        trig[2] = 1'b1;
        step();
        step();
        r2 = ecnt;
        wait_led(2, 1'b0, 60, at);
        check("retrig_extend", at, next_tick_edge(r2, 2));

        // Vector table: high-cycle and transition counts over a window.
        for (int v = 0; v < 7; v++) begin
            reset_release();
            set_ch(vt[v].ch, vt[v].md, vt[v].hp, vt[v].dt);
            repeat (5) step();
            prev = led[vt[v].ch];
            hi = 0;
            tg = 0;
            for (int k = 0; k < vt[v].win; k++) begin
                step();
                if (led[vt[v].ch]) hi++;
                if (led[vt[v].ch] != prev) tg++;
                prev = led[vt[v].ch];
            end
            check($sformatf("vec%0d_high", v), hi, vt[v].exp_hi);
            check($sformatf("vec%0d_toggles", v), tg, vt[v].exp_tg);
        end

        // Random stimulus against a tick-count reference model.
        reset_release();
        for (int c = 0; c < NCH; c++) begin
            pm[c] = 0; ent[c] = 1; endt[c] = 0; th1[c] = 1'b0; th2[c] = 1'b0;
        end
        for (int k = 0; k < 3000; k++) begin
            for (int c = 0; c < NCH; c++) begin
                if ($urandom_range(0, 39) == 0)
                    set_ch(c, 2'((pm[c] + int'($urandom_range(1, 3))) % 4),
                           int'($urandom_range(0, 3)), int'($urandom_range(0, 255)));
                if ($urandom_range(0, 99) == 0)
                    duty[WB*c +: WB] = WB'($urandom_range(0, 255));
                if ($urandom_range(0, 5) == 0)
                    trig[c] = ~trig[c];
            end
            step();
            begin
                int e, t, m, len;
                logic b;
                e = ecnt;
                t = (e - 1) / TD;
                expv = '0;
                for (int c = 0; c < NCH; c++) begin
                    m   = int'(mode[2*c +: 2]);
                    len = int'(half_period[PB*c +: PB]);
                    if (len == 0) len = 1;
                    b = 1'b0;
                    if (m != pm[c]) begin
                        ent[c]  = e;
                        endt[c] = t;
                    end else begin
                        case (m)
                            1: b = (((t - (ent[c] - 1) / TD) / len) % 2) == 1;
                            2: b = ((e - 1) % 256) < int'(duty[WB*c +: WB]);
                            3: begin
                                if (th1[c] && !th2[c]) endt[c] = t + len;
                                b = t < endt[c];
                            end
                            default: b = 1'b0;
                        endcase
                    end
                    expv[c] = b;
                    pm[c]   = m;
                    th2[c]  = th1[c];
                    th1[c]  = trig[c];
                end
                check("rand_led", led, expv);
                check("rand_tick", tick, (e % TD) == 0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
